// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Operands and opcode are registered; the result returns with {S,Z,C,V} flags and a requester tag.
module alu_arbiter #(
  parameter int              DATA_W = 16,
  parameter int              OP_W   = 4,
  parameter logic [OP_W-1:0] OP_NON = '1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [DATA_W-1:0] i_req0_a,
  input  logic [DATA_W-1:0] i_req0_b,
  input  logic [OP_W-1:0]   i_req0_op,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [DATA_W-1:0] i_req1_a,
  input  logic [DATA_W-1:0] i_req1_b,
  input  logic [OP_W-1:0]   i_req1_op,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  output logic [OP_W-1:0]   o_alu_s,
  input  logic [DATA_W-1:0] i_alu_out,
  input  logic [3:0]        i_alu_flag,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic              o_rsp_id,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic [3:0]        o_rsp_flag
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HOLD} state_t;

  state_t            r_state;
  logic              r_last;
  logic              r_id;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [OP_W-1:0]   r_op;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic [3:0]        r_rsp_flag;

  logic              w_can_grant;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_grant;

  // A new grant is possible when idle, or when the held response is being taken this cycle.
  assign w_can_grant = (r_state == S_IDLE) || ((r_state == S_HOLD) && i_rsp_ready);
  assign w_gnt0      = w_can_grant && i_req0_valid && (!i_req1_valid || r_last);
  assign w_gnt1      = w_can_grant && i_req1_valid && (!i_req0_valid || !r_last);
  assign w_grant     = w_gnt0 || w_gnt1;

  assign o_req0_ready = w_gnt0;
  assign o_req1_ready = w_gnt1;
  assign o_alu_a      = r_a;
  assign o_alu_b      = r_b;
  assign o_alu_s      = (r_state == S_EXEC) ? r_op : OP_NON;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_id     = r_id;
  assign o_rsp_data   = r_rsp_data;
  assign o_rsp_flag   = r_rsp_flag;

  // NOTE: reset is synchronous, so it lives inside the clocked block and needs no sensitivity entry;
  // every state register uses non-blocking assignment so all of them update together at the edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;
      r_id        <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= OP_NON;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_flag  <= 4'b0000;
    end else begin
      if (w_grant) begin
        r_a    <= w_gnt1 ? i_req1_a  : i_req0_a;
        r_b    <= w_gnt1 ? i_req1_b  : i_req0_b;
        r_op   <= w_gnt1 ? i_req1_op : i_req0_op;
        r_id   <= w_gnt1;
        r_last <= w_gnt1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_grant) r_state <= S_EXEC;
        end
        S_EXEC: begin
          // The ALU leaves its outputs untouched for the idle opcode, so zero them here.
          r_rsp_data  <= (r_op == OP_NON) ? '0 : i_alu_out;
          r_rsp_flag  <= (r_op == OP_NON) ? 4'b0000 : i_alu_flag;
          r_rsp_valid <= 1'b1;
          r_state     <= S_HOLD;
        end
        S_HOLD: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= w_grant ? S_EXEC : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
